// File: rtl/mem_access_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl_pkg
//   Shared definitions for the load/store sequencer that sits between the
//   core's load/store stage and the data memory.
//   Contents:
//     - RV32I funct3 encodings for loads and stores
//     - FSM state encoding
//     - default read latency of the memory
//     - helpers for request legality, store byte enables and store lanes
// ---------------------------------------------------------------------------
package mem_access_ctrl_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int DEFAULT_RD_LATENCY = 1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WR   = 3'd1,
        ST_RD   = 3'd2,
        ST_WAIT = 3'd3,
        ST_RESP = 3'd4
    } state_t;

    // Unsigned variants exist only for loads, so BU/HU stores are rejected.
    // Halfwords need an even address, words a 4-byte aligned one.
    function automatic logic req_illegal(input logic       we,
                                         input logic [2:0] funct3,
                                         input logic [1:0] byte_off);
        logic bad;
        bad = 1'b0;
        case (funct3)
            F3_B:    bad = 1'b0;
            F3_H:    bad = byte_off[0];
            F3_W:    bad = (byte_off != 2'b00);
            F3_BU:   bad = we;
            F3_HU:   bad = we | byte_off[0];
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [3:0] store_wen(input logic [2:0] funct3,
                                             input logic [1:0] byte_off);
        logic [3:0] wen;
        wen = 4'b0000;
        case (funct3)
            F3_B:    wen = 4'b0001 << byte_off;
            F3_H:    wen = 4'b0011 << byte_off;
            F3_W:    wen = 4'b1111;
            default: wen = 4'b0000;
        endcase
        return wen;
    endfunction

    // The memory picks lanes with the byte enables, so the store data is
    // simply replicated across every lane it could land in.
    function automatic logic [31:0] store_wd(input logic [2:0]  funct3,
                                             input logic [31:0] wdata);
        logic [31:0] wd;
        wd = 32'h0;
        case (funct3)
            F3_B:    wd = {4{wdata[7:0]}};
            F3_H:    wd = {2{wdata[15:0]}};
            F3_W:    wd = wdata;
            default: wd = 32'h0;
        endcase
        return wd;
    endfunction

endpackage

// File: rtl/mem_access_ctrl_load_extend.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl_load_extend
//   Combinational load data alignment and extension.
//   Ports:
//     rd       in  32  raw word from memory
//     byte_off in   2  byte offset of the load inside the word
//     funct3   in   3  RV32I load funct3 (B/H/W/BU/HU)
//     data     out 32  aligned, sign/zero-extended load result
// ---------------------------------------------------------------------------
module mem_access_ctrl_load_extend
    import mem_access_ctrl_pkg::*;
(
    input  logic [31:0] rd,
    input  logic [1:0]  byte_off,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [31:0] shifted;

    // Move the addressed byte/halfword down to bit 0 before extending.
    assign shifted = rd >> {byte_off, 3'b000};

    always_comb begin
        data = 32'h0;
        case (funct3)
            F3_B:    data = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    data = {{16{shifted[15]}}, shifted[15:0]};
            F3_W:    data = shifted;
            F3_BU:   data = {24'h0, shifted[7:0]};
            F3_HU:   data = {16'h0, shifted[15:0]};
            default: data = 32'h0;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl
//   Sequencer between the core load/store stage and the data memory. Takes
//   one load/store per valid/ready handshake, drives word address, byte
//   enables and lane-replicated write data, waits out the memory read
//   latency and returns extended load data or an error. One transaction in
//   flight; every output is registered.
//   Ports:
//     i_clk, i_rstn                 clock, async active-low reset
//     i_req_valid/o_req_ready       request handshake
//     i_req_we/funct3/addr/wdata    request payload (latched on accept)
//     o_rsp_valid/i_rsp_ready       response handshake
//     o_rsp_rdata/o_rsp_err         response payload
//     o_mem_addr/wd/wen/ren         memory command
//     i_mem_rd                      memory read data
// ---------------------------------------------------------------------------
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int HEIGHT         = 256,
    parameter int MEM_RD_LATENCY = DEFAULT_RD_LATENCY
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic [2:0]  i_req_funct3,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_err,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wd,
    output logic [3:0]  o_mem_wen,
    output logic        o_mem_ren,
    input  logic [31:0] i_mem_rd
);

    // 33 bits so that a memory spanning the full 4 GiB still compares correctly.
    localparam logic [32:0] ADDR_LIMIT = 33'(HEIGHT) << 2;
    localparam int          CNT_W      = (MEM_RD_LATENCY > 1) ? $clog2(MEM_RD_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_RD_LATENCY - 1);

    state_t           state;
    logic [2:0]       funct3_q;
    logic [1:0]       off_q;
    logic [CNT_W-1:0] lat_cnt;
    logic [31:0]      load_data;
    logic             req_bad;
    logic             accept;

    assign accept  = o_req_ready & i_req_valid;
    assign req_bad = req_illegal(i_req_we, i_req_funct3, i_req_addr[1:0])
                   | ({1'b0, i_req_addr} >= ADDR_LIMIT);

    mem_access_ctrl_load_extend u_load_extend (
        .rd       (i_mem_rd),
        .byte_off (off_q),
        .funct3   (funct3_q),
        .data     (load_data)
    );

    // Single FSM with registered outputs. o_req_ready only rises on an
    // edge seen in IDLE, so it stays low for the first cycle after reset.
    // The read strobe is sampled by the memory on the edge leaving RD; WAIT
    // then lets MEM_RD_LATENCY edges pass and captures on the last of them.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state       <= ST_IDLE;
            funct3_q    <= 3'b000;
            off_q       <= 2'b00;
            lat_cnt     <= '0;
            o_req_ready <= 1'b0;
            o_rsp_valid <= 1'b0;
            o_rsp_rdata <= 32'h0;
            o_rsp_err   <= 1'b0;
            o_mem_addr  <= 32'h0;
            o_mem_wd    <= 32'h0;
            o_mem_wen   <= 4'b0000;
            o_mem_ren   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        o_req_ready <= 1'b0;
                        funct3_q    <= i_req_funct3;
                        off_q       <= i_req_addr[1:0];
                        if (req_bad) begin
                            o_rsp_valid <= 1'b1;
                            o_rsp_err   <= 1'b1;
                            o_rsp_rdata <= 32'h0;
                            state       <= ST_RESP;
                        end else if (i_req_we) begin
                            o_mem_addr <= {i_req_addr[31:2], 2'b00};
                            o_mem_wen  <= store_wen(i_req_funct3, i_req_addr[1:0]);
                            o_mem_wd   <= store_wd(i_req_funct3, i_req_wdata);
                            state      <= ST_WR;
                        end else begin
                            o_mem_addr <= {i_req_addr[31:2], 2'b00};
                            o_mem_ren  <= 1'b1;
                            state      <= ST_RD;
                        end
                    end else begin
                        o_req_ready <= 1'b1;
                    end
                end
                ST_WR: begin
                    o_mem_wen   <= 4'b0000;
                    o_rsp_valid <= 1'b1;
                    o_rsp_err   <= 1'b0;
                    o_rsp_rdata <= 32'h0;
                    state       <= ST_RESP;
                end
                ST_RD: begin
                    o_mem_ren <= 1'b0;
                    lat_cnt   <= '0;
                    state     <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (lat_cnt == CNT_LAST) begin
                        o_rsp_rdata <= load_data;
                        o_rsp_err   <= 1'b0;
                        o_rsp_valid <= 1'b1;
                        state       <= ST_RESP;
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    if (i_rsp_ready) begin
                        o_rsp_valid <= 1'b0;
                        o_rsp_rdata <= 32'h0;
                        o_rsp_err   <= 1'b0;
                        o_mem_addr  <= 32'h0;
                        o_mem_wd    <= 32'h0;
                        o_req_ready <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_access_ctrl
//   Bench for mem_access_ctrl with a word-array data memory (read latency 1)
//   behind it. A transaction-level reference model predicts every output on
//   every cycle; directed vectors add hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_mem_access_ctrl;

    localparam int HEIGHT = 256;
    localparam int LAT    = 1;

    logic        clk;
    logic        rstn;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic [3:0]  mem_wen;
    logic        mem_ren;
    logic [31:0] mem_rd;

    int checks = 0;
    int errors = 0;

    mem_access_ctrl #(.HEIGHT(HEIGHT), .MEM_RD_LATENCY(LAT)) dut (
        .i_clk        (clk),
        .i_rstn       (rstn),
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .i_req_we     (req_we),
        .i_req_funct3 (req_funct3),
        .i_req_addr   (req_addr),
        .i_req_wdata  (req_wdata),
        .o_rsp_valid  (rsp_valid),
        .i_rsp_ready  (rsp_ready),
        .o_rsp_rdata  (rsp_rdata),
        .o_rsp_err    (rsp_err),
        .o_mem_addr   (mem_addr),
        .o_mem_wd     (mem_wd),
        .o_mem_wen    (mem_wen),
        .o_mem_ren    (mem_ren),
        .i_mem_rd     (mem_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory stand-in: byte-enabled writes, one-cycle registered read.
    logic [31:0] mem_words [HEIGHT];

    always @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (mem_wen[b]) mem_words[mem_addr[9:2]][8*b +: 8] <= mem_wd[8*b +: 8];
        if (mem_ren) mem_rd <= mem_words[mem_addr[9:2]];
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic reportTimeout(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: timed out waiting for DUT at %0t", name, $time);
    endtask

    // Reference model: a byte array for memory contents plus a description of
    // the one outstanding transaction (accept time and predicted results).
    logic [7:0]  ref_mem [HEIGHT*4];
    int          cyc;
    int          acc;
    int          rsp_d;
    bit          busy;
    bit          m_ready;
    bit          m_err;
    bit          m_we;
    int          m_size;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic [3:0]  m_mask;
    logic [31:0] m_wd;

    function automatic bit legalFunct3(input bit we, input logic [2:0] f3);
        if (we) return (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
        return (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    endfunction

    always @(posedge clk or negedge rstn) begin
        int d_prev;
        int off;
        if (!rstn) begin
            cyc     = 0;
            busy    = 0;
            m_ready = 0;
        end else begin
            d_prev = cyc - acc;
            cyc++;
            if (busy) begin
                // Store lands in memory on the edge that ends its write cycle.
                if (!m_err && m_we && d_prev == 0)
                    for (int i = 0; i < m_size; i++) ref_mem[m_addr + i] = m_wdata[8*i +: 8];
                if (d_prev >= rsp_d && rsp_ready) begin
                    busy    = 0;
                    m_ready = 1;
                end
            end else if (m_ready && req_valid) begin
                m_ready = 0;
                busy    = 1;
                acc     = cyc;
                m_we    = req_we;
                m_addr  = req_addr;
                m_wdata = req_wdata;
                m_size  = 1 << req_funct3[1:0];
                off     = int'(req_addr[1:0]);
                m_err   = !legalFunct3(req_we, req_funct3) || (req_addr % m_size != 0)
                          || (req_addr >= 32'(HEIGHT * 4));
                rsp_d   = m_err ? 0 : (req_we ? 1 : 1 + LAT);
                m_mask  = 4'b0000;
                m_wd    = 32'h0;
                m_rdata = 32'h0;
                if (!m_err && req_we) begin
                    for (int i = 0; i < m_size; i++) m_mask[off + i] = 1'b1;
                    for (int j = 0; j < 4; j++) m_wd[8*j +: 8] = req_wdata[8*(j % m_size) +: 8];
                end
                if (!m_err && !req_we) begin
                    for (int i = 0; i < m_size; i++) m_rdata[8*i +: 8] = ref_mem[req_addr + i];
                    if (!req_funct3[2] && m_size == 1) m_rdata = {{24{m_rdata[7]}}, m_rdata[7:0]};
                    if (!req_funct3[2] && m_size == 2) m_rdata = {{16{m_rdata[15]}}, m_rdata[15:0]};
                end
            end else begin
                m_ready = 1;
            end
        end
    end

    // Compare process: every cycle, all outputs against the model's prediction.
    always @(negedge clk) begin
        int          d;
        logic [3:0]  e_wen;
        logic        e_ren;
        logic        e_rv;
        d     = cyc - acc;
        e_wen = (busy && !m_err && m_we && d == 0) ? m_mask : 4'b0000;
        e_ren = busy && !m_err && !m_we && d == 0;
        e_rv  = busy && d >= rsp_d;
        checkOutput("req_ready", req_ready, m_ready);
        checkOutput("mem_wen", mem_wen, e_wen);
        checkOutput("mem_ren", mem_ren, e_ren);
        checkOutput("rsp_valid", rsp_valid, e_rv);
        checkOutput("rsp_rdata", rsp_rdata, e_rv ? m_rdata : 32'h0);
        checkOutput("rsp_err", rsp_err, e_rv && m_err);
        if (e_wen != 4'b0000) checkOutput("mem_wd", mem_wd, m_wd);
        if (e_wen != 4'b0000 || e_ren) checkOutput("mem_addr", mem_addr, {m_addr[31:2], 2'b00});
        if (!busy) begin
            checkOutput("idle_mem_addr", mem_addr, 32'h0);
            checkOutput("idle_mem_wd", mem_wd, 32'h0);
        end
    end

    // Records what the DUT put on the memory bus during the current request.
    bit          seen_access;
    logic [3:0]  last_wen;
    logic [31:0] last_wd;

    always @(negedge clk) begin
        if (mem_wen != 4'b0000) begin
            seen_access = 1;
            last_wen    = mem_wen;
            last_wd     = mem_wd;
        end
        if (mem_ren) seen_access = 1;
    end

    // One complete transaction; payload is scrambled after accept so any
    // dependence on unlatched inputs shows up. During 'hold' cycles the
    // response is left pending while a second request is presented.
    task automatic applyStimulus(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wdata, input int hold,
                                 output logic [31:0] rdata, output logic err, output int lat);
        int n;
        rdata = 32'h0;
        err   = 1'b0;
        lat   = 0;
        @(posedge clk); #1;
        req_we      = we;
        req_funct3  = f3;
        req_addr    = addr;
        req_wdata   = wdata;
        req_valid   = 1'b1;
        rsp_ready   = 1'b0;
        seen_access = 0;
        last_wen    = 4'b0000;
        last_wd     = 32'h0;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            reportTimeout("accept");
            req_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        req_valid  = 1'b0;
        req_we     = ~we;
        req_funct3 = ~f3;
        req_addr   = ~addr;
        req_wdata  = ~wdata;
        do begin
            @(negedge clk);
            lat++;
        end while (!rsp_valid && lat < 50);
        if (!rsp_valid) begin
            reportTimeout("response");
            return;
        end
        for (int h = 0; h < hold; h++) begin
            req_valid = 1'b1;
            @(negedge clk);
            checkOutput("busy_ready_low", req_ready, 1'b0);
        end
        req_valid = 1'b0;
        rdata     = rsp_rdata;
        err       = rsp_err;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lt;
        int          n;

        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lt;
        int          n;

        for (int i = 0; i < HEIGHT; i++) mem_words[i] = 32'h0;
        for (int i = 0; i < HEIGHT * 4; i++) ref_mem[i] = 8'h0;
        acc        = 0;
        rsp_d      = 0;
        m_err      = 0;
        m_we       = 0;
        m_size     = 1;
        m_addr     = 32'h0;
        m_wdata    = 32'h0;
        m_rdata    = 32'h0;
        m_mask     = 4'b0000;
        m_wd       = 32'h0;
        mem_rd     = 32'h0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        rsp_ready  = 1'b0;
        rstn       = 1'b1;
        #1 rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        checkOutput("reset_ready_low", req_ready, 1'b0);
        checkOutput("reset_rsp_valid", rsp_valid, 1'b0);
        @(posedge clk); #1;
        checkOutput("ready_after_release", req_ready, 1'b1);

        // Word store then load.
        applyStimulus(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 0, rd, er, lt);
        checkOutput("sw_latency", lt, 2);
        checkOutput("sw_err", er, 1'b0);
        applyStimulus(1'b0, 3'b010, 32'h10, 32'h0, 0, rd, er, lt);
        checkOutput("lw_latency", lt, 3);
        checkOutput("lw_rdata", rd, 32'hDEADBEEF);

        // Byte store into the top lane, signed and unsigned byte loads.
        applyStimulus(1'b1, 3'b000, 32'h13, 32'h12345680, 0, rd, er, lt);
        checkOutput("sb_wen", last_wen, 4'b1000);
        applyStimulus(1'b0, 3'b000, 32'h13, 32'h0, 0, rd, er, lt);
        checkOutput("lb_rdata", rd, 32'hFFFFFF80);
        applyStimulus(1'b0, 3'b100, 32'h13, 32'h0, 0, rd, er, lt);
        checkOutput("lbu_rdata", rd, 32'h00000080);
        checkOutput("mem_word_0x10", mem_words[4], 32'h80ADBEEF);
        applyStimulus(1'b0, 3'b101, 32'h12, 32'h0, 0, rd, er, lt);
        checkOutput("lhu_rdata", rd, 32'h000080AD);
        applyStimulus(1'b0, 3'b001, 32'h12, 32'h0, 0, rd, er, lt);
        checkOutput("lh_neg_rdata", rd, 32'hFFFF80AD);

        // Upper halfword store and load.
        applyStimulus(1'b1, 3'b001, 32'h22, 32'h00001234, 0, rd, er, lt);
        checkOutput("sh_wen", last_wen, 4'b1100);
        checkOutput("sh_wd", last_wd, 32'h12341234);
        applyStimulus(1'b0, 3'b001, 32'h22, 32'h0, 0, rd, er, lt);
        checkOutput("lh_rdata", rd, 32'h00001234);
        applyStimulus(1'b1, 3'b000, 32'h21, 32'h0000005A, 0, rd, er, lt);
        checkOutput("sb_lane1_wen", last_wen, 4'b0010);
        checkOutput("sb_lane1_wd", last_wd, 32'h5A5A5A5A);

        // Illegal requests: misaligned, bad funct3, out of range.
        applyStimulus(1'b0, 3'b010, 32'h11, 32'h0, 0, rd, er, lt);
        checkOutput("lw_mis_err", er, 1'b1);
        checkOutput("lw_mis_rdata", rd, 32'h0);
        checkOutput("lw_mis_latency", lt, 1);
        checkOutput("lw_mis_no_access", seen_access, 1'b0);
        applyStimulus(1'b0, 3'b001, 32'h03, 32'h0, 0, rd, er, lt);
        checkOutput("lh_mis_err", er, 1'b1);
        checkOutput("lh_mis_no_access", seen_access, 1'b0);
        applyStimulus(1'b0, 3'b011, 32'h00, 32'h0, 0, rd, er, lt);
        checkOutput("f3_011_err", er, 1'b1);
        checkOutput("f3_011_no_access", seen_access, 1'b0);
        applyStimulus(1'b0, 3'b010, 32'h400, 32'h0, 0, rd, er, lt);
        checkOutput("lw_oor_err", er, 1'b1);
        checkOutput("lw_oor_rdata", rd, 32'h0);
        checkOutput("lw_oor_no_access", seen_access, 1'b0);
        applyStimulus(1'b1, 3'b100, 32'h30, 32'hFFFFFFFF, 0, rd, er, lt);
        checkOutput("sbu_err", er, 1'b1);
        checkOutput("sbu_no_access", seen_access, 1'b0);

        // Response held back for 5 cycles while another request waits.
        applyStimulus(1'b0, 3'b010, 32'h20, 32'h0, 5, rd, er, lt);
        checkOutput("hold_rdata", rd, 32'h12345A00);
        checkOutput("hold_err", er, 1'b0);

        // Reset asserted in the middle of a word store.
        applyStimulus(1'b1, 3'b010, 32'h40, 32'h11223344, 0, rd, er, lt);
        @(posedge clk); #1;
        req_we     = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h40;
        req_wdata  = 32'hAAAAAAAA;
        req_valid  = 1'b1;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) reportTimeout("rst_accept");
        @(posedge clk); #1;
        req_valid = 1'b0;
        #2;
        checkOutput("wr_wen_before_rst", mem_wen, 4'b1111);
        rstn = 1'b0;
        #1;
        checkOutput("rst_wen_drop", mem_wen, 4'b0000);
        checkOutput("rst_ready_drop", req_ready, 1'b0);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        checkOutput("rst_ready_still_low", req_ready, 1'b0);
        @(posedge clk); #1;
        checkOutput("rst_ready_rise", req_ready, 1'b1);
        checkOutput("rst_word_kept", mem_words[16], 32'h11223344);
        applyStimulus(1'b0, 3'b010, 32'h40, 32'h0, 0, rd, er, lt);
        checkOutput("rst_lw_rdata", rd, 32'h11223344);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
